// File: rtl/cs_serial_resolver.sv
// rtl/cs_serial_resolver.sv - bit-serial carry-save resolver
// Ripples a 5:2 counter (s, c) column stream through one full adder into a binary result.
module cs_serial_resolver #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic             in_first,
   input  logic             col_s,
   input  logic             col_c,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH+1:0] sum
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, DONE} state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   col_cnt;
   logic            cprev;
   logic            cy;
   logic [WIDTH+1:0] res;

   logic accept;
   logic take;
   logic cp_eff;
   logic cy_eff;
   logic bit_res;
   logic last_col;

   assign accept   = in_valid & in_ready;
   // Column 0 starts a fresh ripple, so stale carries are masked off.
   assign cp_eff   = cprev & ~in_first;
   assign cy_eff   = cy & ~in_first;
   assign bit_res  = col_s ^ cp_eff ^ cy_eff;
   assign last_col = ~in_first & (col_cnt == CW'(WIDTH - 1));
   assign take     = accept & (in_first | (state == ACCUM));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept && in_first) state_nxt = ACCUM;
         ACCUM:   if (accept && last_col) state_nxt = FLUSH;
         FLUSH:   state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE) || (state == ACCUM);
      out_valid = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cy      <= 1'b0;
         cprev   <= 1'b0;
         col_cnt <= '0;
         res     <= '0;
      end else if (take) begin
         cy                 <= (col_s & cp_eff) | (col_s & cy_eff) | (cp_eff & cy_eff);
         cprev              <= col_c;
         res[WIDTH-1:0]     <= {bit_res, res[WIDTH-1:1]};
         res[WIDTH+1:WIDTH] <= 2'b00;
         col_cnt            <= in_first ? CW'(1) : col_cnt + CW'(1);
      end else if (state == FLUSH) begin
         // Pending carries of weight 2^WIDTH: cprev and cy add into the top two bits.
         res[WIDTH+1:WIDTH] <= {cprev & cy, cprev ^ cy};
      end else if ((state == DONE) && out_ready) begin
         cy      <= 1'b0;
         cprev   <= 1'b0;
         col_cnt <= '0;
      end
   end

   assign sum = res;

endmodule

// File: tb/tb_cs_serial_resolver.sv
// tb/tb_cs_serial_resolver.sv - scoreboard bench for cs_serial_resolver
module tb_cs_serial_resolver;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_first;
   logic         col_s;
   logic         col_c;
   logic         in_ready;
   logic         out_valid;
   logic         out_ready;
   logic [W+1:0] sum;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int hs_edge = -1;
   bit rand_ready = 0;
   bit ready_force = 1;
   logic [W+1:0] exp_q[$];

   cs_serial_resolver #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_first(in_first),
      .col_s(col_s), .col_c(col_c), .in_ready(in_ready), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      out_ready = 1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
      end
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Handshake happens at the edge following this negedge sample.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         hs_edge = cyc + 1;
         if (exp_q.size() == 0) check_val("spurious_out", 1, 0);
         else check_val("sum", 32'(sum), 32'(exp_q.pop_front()));
      end
   end

   task automatic drive_beat(input logic first, input logic s, input logic c, output int e);
      bit ok;
      ok = 0;
      e = -1;
      in_valid = 1;
      in_first = first;
      col_s = s;
      col_c = c;
      for (int t = 0; t < 64; t++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         if (ok) begin
            e = cyc;
            break;
         end
      end
      if (!ok) check_val("beat_timeout", 0, 1);
      in_valid = 0;
   endtask

   task automatic send_frame(input logic [W-1:0] s, input logic [W-1:0] c, input int gaps,
                             output int first_e, output int last_e);
      int left;
      int e;
      logic [W+1:0] ev;
      left = gaps;
      first_e = -1;
      last_e = -1;
      ev = {2'b00, s} + {1'b0, c, 1'b0};
      exp_q.push_back(ev);
      for (int k = 0; k < W; k++) begin
         if (k > 0 && left > 0 && ($urandom_range(0, 1) == 1 || (W - k) <= left)) begin
            in_valid = 0;
            @(posedge clk);
            #1;
            left--;
         end
         drive_beat(k == 0, s[k], c[k], e);
         if (k == 0) first_e = e;
         last_e = e;
      end
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 400; t++) begin
         if (exp_q.size() == 0) break;
         @(posedge clk);
      end
      check_val("drain", exp_q.size(), 0);
   endtask

   initial begin
      int f, l, e;
      logic [W+1:0] hold_exp;
      rst_n = 0;
      in_valid = 0;
      in_first = 0;
      col_s = 0;
      col_c = 0;
      #3;
      check_val("rst_out_valid", 32'(out_valid), 0);
      check_val("rst_sum", 32'(sum), 0);
      check_val("rst_in_ready", 32'(in_ready), 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;

      // all-ones columns and exact latency
      send_frame(8'hFF, 8'hFF, 0, f, l);
      check_val("lat_flush_valid", 32'(out_valid), 0);
      check_val("lat_flush_ready", 32'(in_ready), 0);
      @(posedge clk);
      #1;
      check_val("lat_valid_rise", 32'(out_valid), 1);
      check_val("lat_sum_765", 32'(sum), 32'h2FD);
      wait_drain();

      send_frame(8'h01, 8'h00, 0, f, l);
      send_frame(8'h00, 8'hFF, 0, f, l);
      wait_drain();

      // same frames with 3 idle cycles mid-frame
      send_frame(8'h01, 8'h00, 3, f, l);
      check_val("gap_span_a", l - f, W - 1 + 3);
      @(posedge clk);
      #1;
      check_val("gap_valid_a", 32'(out_valid), 1);
      send_frame(8'h00, 8'hFF, 3, f, l);
      check_val("gap_span_b", l - f, W - 1 + 3);
      @(posedge clk);
      #1;
      check_val("gap_valid_b", 32'(out_valid), 1);
      wait_drain();

      // output held while downstream stalls
      ready_force = 0;
      repeat (2) @(posedge clk);
      send_frame(8'h5A, 8'hC3, 0, f, l);
      hold_exp = 10'h05A + 10'h186;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_val("hold_valid", 32'(out_valid), 1);
         check_val("hold_sum", 32'(sum), 32'(hold_exp));
         check_val("hold_in_ready", 32'(in_ready), 0);
      end
      ready_force = 1;
      send_frame(8'h33, 8'h81, 0, f, l);
      check_val("accept_after_hs", f, hs_edge + 1);
      wait_drain();

      // restart mid-frame, then discarded beats in IDLE
      drive_beat(1, 1, 0, e);
      drive_beat(0, 1, 1, e);
      drive_beat(0, 0, 1, e);
      send_frame(8'hFF, 8'hFF, 0, f, l);
      wait_drain();
      drive_beat(0, 1, 1, e);
      drive_beat(0, 1, 1, e);
      drive_beat(0, 0, 1, e);
      check_val("idle_discard_valid", 32'(out_valid), 0);
      send_frame(8'h0F, 8'hF0, 0, f, l);
      wait_drain();

      // asynchronous reset mid-frame
      drive_beat(1, 1, 1, e);
      for (int i = 0; i < 4; i++) drive_beat(0, 1, 1, e);
      #2 rst_n = 0;
      #1;
      check_val("async_out_valid", 32'(out_valid), 0);
      check_val("async_sum", 32'(sum), 0);
      check_val("async_in_ready", 32'(in_ready), 1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1;
      send_frame(8'hA5, 8'h3C, 0, f, l);
      wait_drain();

      // random frames with valid and ready gaps
      rand_ready = 1;
      for (int n = 0; n < 1000; n++) begin
         send_frame(W'($urandom), W'($urandom), $urandom_range(0, 3), f, l);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      wait_drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/cs_serial_resolver.md
# cs_serial_resolver

Bit-serial carry-save resolver that sits directly downstream of the 5:2 column counter. The counter reduces one bit-column of five operands per cycle into a sum bit `s` (weight 2^k) and a carry bit `c` (weight 2^(k+1)). This block consumes that (s, c) stream LSB-column first and ripples it through a single full adder with registered carries. After WIDTH columns plus one flush cycle it presents the fully resolved binary result on a valid/ready output.

## Interface
- WIDTH, 8, number of bit-columns per frame (WIDTH >= 2); result width is WIDTH+2
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  column (col_s, col_c) present
- in_first  input  1  qualifies column 0 of a frame; meaningful only with in_valid
- col_s  input  1  counter sum bit for current column k (weight 2^k)
- col_c  input  1  counter carry bit for current column k (weight 2^(k+1))
- in_ready  output  1  block accepts a column this cycle
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH+2  resolved result = Σ(s_k·2^k + c_k·2^(k+1)), k=0..WIDTH-1

## Operation
- States: IDLE, ACCUM, FLUSH, DONE. in_ready = 1 in IDLE/ACCUM, 0 in FLUSH/DONE (decoded from state register). out_valid = 1 only in DONE.
- Registers: cprev (previous column's col_c), cy (adder carry), col counter (clog2(WIDTH+1) bits), res shift register (WIDTH+2 bits).
- Accept = in_valid & in_ready, sampled at the rising edge.
- IDLE: an accepted beat with in_first=1 is column 0 → ACCUM. An accepted beat with in_first=0 is consumed and discarded; state stays IDLE.
- Column update, with effective cprev/cy forced to 0 when in_first=1:
  - bit = col_s ^ cprev ^ cy
  - cy ← maj(col_s, cprev, cy)
  - cprev ← col_c
  - res shifts right with bit entering at position WIDTH-1; the counter increments.
- ACCUM, in_first=1: restart. Partial frame discarded; the beat is treated as a new column 0 (counter reloads to 1, carries cleared).
- After the WIDTH-th accepted column → FLUSH.
- FLUSH, one cycle: sum[WIDTH] = cprev ^ cy, sum[WIDTH+1] = cprev & cy, sum[WIDTH-1:0] = resolved bits 0..WIDTH-1 → DONE.
- DONE: sum and out_valid held stable until out_valid & out_ready at an edge → IDLE, with cy, cprev and the counter cleared.
- No overflow is possible: the maximum result 3·(2^WIDTH − 1) fits in WIDTH+2 bits.

## Timing
- Reset (rst_n low, async): state IDLE, out_valid 0, sum 0, cy 0, cprev 0, counter 0. in_ready reads 1 but no beat is accepted while rst_n is low. Reset is released synchronously by the system.
- Reset mid-frame: partial result lost; the first beat accepted afterwards must carry in_first=1.
- Throughput: one column per cycle while in_valid is high. Gaps (in_valid=0) in ACCUM freeze all registers.
- Latency: last column accepted at edge E → FLUSH during the following cycle → out_valid rises at edge E+1. Sum is stable from that edge.
- Minimum frame period: WIDTH + 2 cycles, i.e. WIDTH accepts, 1 FLUSH, ≥1 DONE.
- in_valid during FLUSH/DONE: not accepted. The upstream holds the beat until in_ready returns; earliest acceptance is the edge after the output handshake.
- out_ready high before DONE has no effect. Result transfer occurs only at an edge where out_valid=1.

## Test plan
- WIDTH=8, reset, then 8 columns with s=1,c=1 → sum = 0x2FD (765); out_valid rises exactly 1 edge after the 8th accept.
- Column 0 (s=1,c=0) followed by 7 zero columns → sum = 0x001. Next frame, all columns s=0,c=1 → sum = 0x1FE (510).
- Same frames with in_valid deasserted for 3 random cycles mid-frame → identical sums; out_valid delayed by exactly 3 cycles.
- out_ready low for 4 cycles in DONE → sum and out_valid held, in_ready 0. Then frame 2 is accepted only after the handshake edge.
- 3 columns accepted, then in_first=1 restarts with s=1,c=1 ×8 → sum = 765; the partial frame has no effect. Beats with in_first=0 in IDLE are discarded.
- rst_n pulsed low after 5 columns → outputs return to reset values immediately (async); a following clean frame gives the correct sum.
- Random: 1000 frames, random s/c and valid/ready gaps → sum equals Σ(s_k·2^k + c_k·2^(k+1)).
